// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: shares one big-endian, byte-addressed data memory between
// the CPU load/store port (A) and the loader/debug port (B). Each access takes
// exactly three cycles: the request is latched, the memory is driven for one
// cycle, and the response is returned. Misaligned, out-of-range and illegal
// accesses are rejected without touching memory.
module dm_access_arbiter #(
  parameter int MEM_BYTES = 64,
  parameter int FAIR      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ReqA,
  input  logic        ReqB,
  input  logic [31:0] AddrA,
  input  logic [31:0] AddrB,
  input  logic        WrA,
  input  logic        WrB,
  input  logic [2:0]  CtrlA,
  input  logic [2:0]  CtrlB,
  input  logic [31:0] DataWrA,
  input  logic [31:0] DataWrB,
  output logic        GntA,
  output logic        GntB,
  output logic        RdyA,
  output logic        RdyB,
  output logic [31:0] DataRdA,
  output logic [31:0] DataRdB,
  output logic        ErrA,
  output logic        ErrB,
  output logic [31:0] DMAddress,
  output logic [31:0] DMDataWr,
  output logic        DMWr,
  output logic [2:0]  DMCtrl,
  input  logic [31:0] DMDataRd
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam bit FairRR = (FAIR != 0);

  state_t      state_q;
  logic        last_b_q;   // 1: B was granted most recently
  logic        sel_b_q;    // 1: current access belongs to B
  logic [31:0] addr_q;
  logic        wr_q;
  logic [2:0]  ctrl_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        gnt_a_q, gnt_b_q, rdy_a_q, rdy_b_q, err_a_q, err_b_q;
  logic [31:0] rd_a_q, rd_b_q;

  logic        sel_b_d;
  logic [31:0] addr_d;
  logic        wr_d;
  logic [2:0]  ctrl_d;
  logic [31:0] data_d;
  logic        err_d;
  logic [31:0] rd_d;

  // Rejects illegal size codes, sign-extending stores, misalignment, and any
  // access whose last byte falls past the end of memory (33-bit, no wrap).
  function automatic logic access_err(input logic [31:0] addr, input logic wr,
                                      input logic [2:0] ctrl);
    logic [32:0] size;
    logic [32:0] last;
    logic        err;
    err = 1'b0;
    case (ctrl)
      3'b000, 3'b100: size = 33'd1;
      3'b001, 3'b101: size = 33'd2;
      3'b010:         size = 33'd4;
      default: begin
        size = 33'd1;
        err  = 1'b1;
      end
    endcase
    if (wr && ctrl[2]) err = 1'b1;
    if ((ctrl[1:0] == 2'b01) && addr[0]) err = 1'b1;
    if ((ctrl == 3'b010) && (addr[1:0] != 2'b00)) err = 1'b1;
    last = {1'b0, addr} + size - 33'd1;
    if (last >= 33'(MEM_BYTES)) err = 1'b1;
    return err;
  endfunction

  // Winner selection and the request fields that get latched from it.
  always_comb begin
    sel_b_d = ReqB && (!ReqA || (FairRR && !last_b_q));
    addr_d  = sel_b_d ? AddrB   : AddrA;
    wr_d    = sel_b_d ? WrB     : WrA;
    ctrl_d  = sel_b_d ? CtrlB   : CtrlA;
    data_d  = sel_b_d ? DataWrB : DataWrA;
    err_d   = access_err(addr_d, wr_d, ctrl_d);
    rd_d    = (wr_q || err_q) ? 32'd0 : DMDataRd;
  end

  // Memory port is live only in ACCESS; elsewhere it idles as a word read at 0.
  always_comb begin
    DMWr      = 1'b0;
    DMAddress = 32'd0;
    DMDataWr  = 32'd0;
    DMCtrl    = 3'b010;
    if (state_q == S_ACCESS) begin
      DMWr      = wr_q && !err_q && !rst;
      DMAddress = addr_q;
      DMDataWr  = data_q;
      DMCtrl    = ctrl_q;
    end
  end

  // Access FSM: IDLE latches a request, ACCESS drives memory, RESP answers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_b_q <= 1'b1;
      sel_b_q  <= 1'b0;
      addr_q   <= 32'd0;
      wr_q     <= 1'b0;
      ctrl_q   <= 3'b000;
      data_q   <= 32'd0;
      err_q    <= 1'b0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      rdy_a_q  <= 1'b0;
      rdy_b_q  <= 1'b0;
      err_a_q  <= 1'b0;
      err_b_q  <= 1'b0;
      rd_a_q   <= 32'd0;
      rd_b_q   <= 32'd0;
    end else begin
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      rdy_a_q <= 1'b0;
      rdy_b_q <= 1'b0;
      err_a_q <= 1'b0;
      err_b_q <= 1'b0;
      rd_a_q  <= 32'd0;
      rd_b_q  <= 32'd0;
      case (state_q)
        S_IDLE: begin
          if (ReqA || ReqB) begin
            sel_b_q  <= sel_b_d;
            last_b_q <= sel_b_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            ctrl_q   <= ctrl_d;
            data_q   <= data_d;
            err_q    <= err_d;
            gnt_a_q  <= !sel_b_d;
            gnt_b_q  <= sel_b_d;
            state_q  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          rdy_a_q <= !sel_b_q;
          rdy_b_q <= sel_b_q;
          err_a_q <= !sel_b_q && err_q;
          err_b_q <= sel_b_q && err_q;
          rd_a_q  <= sel_b_q ? 32'd0 : rd_d;
          rd_b_q  <= sel_b_q ? rd_d : 32'd0;
          state_q <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign GntA    = gnt_a_q;
  assign GntB    = gnt_b_q;
  assign RdyA    = rdy_a_q;
  assign RdyB    = rdy_b_q;
  assign ErrA    = err_a_q;
  assign ErrB    = err_b_q;
  assign DataRdA = rd_a_q;
  assign DataRdB = rd_b_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter with a big-endian byte memory model.
// A second instance with FAIR=0 shares the stimulus for the priority checks.
module tb_dm_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ReqA, ReqB, WrA, WrB;
  logic [31:0] AddrA, AddrB, DataWrA, DataWrB;
  logic [2:0]  CtrlA, CtrlB;
  logic        GntA, GntB, RdyA, RdyB, ErrA, ErrB, DMWr;
  logic [31:0] DataRdA, DataRdB, DMAddress, DMDataWr, DMDataRd;
  logic [2:0]  DMCtrl;
  logic        GntA0, GntB0, RdyA0, RdyB0, ErrA0, ErrB0, DMWr0;
  logic [31:0] DataRdA0, DataRdB0, DMAddress0, DMDataWr0;
  logic [2:0]  DMCtrl0;
  logic [31:0] zero_rd;

  logic [7:0]  mem [64] = '{default: 8'h00};
  int          wr_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  assign zero_rd = 32'd0;

  dm_access_arbiter #(.MEM_BYTES(64), .FAIR(1)) dut (
    .clk(clk), .rst(rst), .ReqA(ReqA), .ReqB(ReqB), .AddrA(AddrA), .AddrB(AddrB),
    .WrA(WrA), .WrB(WrB), .CtrlA(CtrlA), .CtrlB(CtrlB), .DataWrA(DataWrA),
    .DataWrB(DataWrB), .GntA(GntA), .GntB(GntB), .RdyA(RdyA), .RdyB(RdyB),
    .DataRdA(DataRdA), .DataRdB(DataRdB), .ErrA(ErrA), .ErrB(ErrB),
    .DMAddress(DMAddress), .DMDataWr(DMDataWr), .DMWr(DMWr), .DMCtrl(DMCtrl),
    .DMDataRd(DMDataRd));

  dm_access_arbiter #(.MEM_BYTES(64), .FAIR(0)) dut0 (
    .clk(clk), .rst(rst), .ReqA(ReqA), .ReqB(ReqB), .AddrA(AddrA), .AddrB(AddrB),
    .WrA(WrA), .WrB(WrB), .CtrlA(CtrlA), .CtrlB(CtrlB), .DataWrA(DataWrA),
    .DataWrB(DataWrB), .GntA(GntA0), .GntB(GntB0), .RdyA(RdyA0), .RdyB(RdyB0),
    .DataRdA(DataRdA0), .DataRdB(DataRdB0), .ErrA(ErrA0), .ErrB(ErrB0),
    .DMAddress(DMAddress0), .DMDataWr(DMDataWr0), .DMWr(DMWr0), .DMCtrl(DMCtrl0),
    .DMDataRd(zero_rd));

  function automatic logic [7:0] rb(input logic [31:0] a);
    return (a < 32'd64) ? mem[a[5:0]] : 8'h00;
  endfunction

  // Level-sensitive read port of the memory model.
  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = rb(DMAddress);
    b1 = rb(DMAddress + 32'd1);
    b2 = rb(DMAddress + 32'd2);
    b3 = rb(DMAddress + 32'd3);
    case (DMCtrl)
      3'b000:  DMDataRd = {{24{b0[7]}}, b0};
      3'b100:  DMDataRd = {24'h0, b0};
      3'b001:  DMDataRd = {{16{b0[7]}}, b0, b1};
      3'b101:  DMDataRd = {16'h0, b0, b1};
      default: DMDataRd = {b0, b1, b2, b3};
    endcase
  end

  // Write port of the memory model, plus a count of write-enable cycles.
  always @(posedge clk) begin
    if (DMWr) begin
      wr_cnt <= wr_cnt + 1;
      if (DMAddress <= 32'd60) begin
        case (DMCtrl[1:0])
          2'b00: mem[DMAddress[5:0]] <= DMDataWr[7:0];
          2'b01: begin
            mem[DMAddress[5:0]]         <= DMDataWr[15:8];
            mem[DMAddress[5:0] + 6'd1]  <= DMDataWr[7:0];
          end
          default: begin
            mem[DMAddress[5:0]]         <= DMDataWr[31:24];
            mem[DMAddress[5:0] + 6'd1]  <= DMDataWr[23:16];
            mem[DMAddress[5:0] + 6'd2]  <= DMDataWr[15:8];
            mem[DMAddress[5:0] + 6'd3]  <= DMDataWr[7:0];
          end
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete access on one port, checked cycle by cycle.
  task automatic access(input bit port_b, input logic wr, input logic [2:0] ctrl,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic exp_err, input logic [31:0] exp_rd, input string tag);
    int  wc0;
    logic exp_wr;
    exp_wr = wr && !exp_err;
    @(negedge clk);
    if (port_b) begin
      ReqB = 1'b1; WrB = wr; CtrlB = ctrl; AddrB = addr; DataWrB = data;
    end else begin
      ReqA = 1'b1; WrA = wr; CtrlA = ctrl; AddrA = addr; DataWrA = data;
    end
    #1;
    check({tag, "_gnt_early"}, 32'(port_b ? GntB : GntA), 32'd0);
    wc0 = wr_cnt;
    @(negedge clk);
    check({tag, "_gnt"}, 32'(port_b ? GntB : GntA), 32'd1);
    check({tag, "_dmwr"}, 32'(DMWr), 32'(exp_wr));
    ReqA = 1'b0;
    ReqB = 1'b0;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(port_b ? RdyB : RdyA), 32'd1);
    check({tag, "_err"}, 32'(port_b ? ErrB : ErrA), 32'(exp_err));
    check({tag, "_rd"}, port_b ? DataRdB : DataRdA, exp_rd);
    check({tag, "_wrcnt"}, 32'(wr_cnt - wc0), 32'(exp_wr));
  endtask

  initial begin
    logic [3:0] gs, gs0;
    int         n, n0, wc0;
    logic       found;
    rst = 1'b1;
    ReqA = 1'b0; ReqB = 1'b0; WrA = 1'b0; WrB = 1'b0;
    AddrA = 32'd0; AddrB = 32'd0; CtrlA = 3'b010; CtrlB = 3'b010;
    DataWrA = 32'd0; DataWrB = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_gnt", {30'd0, GntA, GntB}, 32'd0);
    check("rst_rdy_err", {28'd0, RdyA, RdyB, ErrA, ErrB}, 32'd0);
    check("rst_datard", DataRdA | DataRdB, 32'd0);
    check("rst_dmctrl", {28'd0, DMWr, DMCtrl}, 32'h2);
    check("rst_dmaddr", DMAddress, 32'd0);
    rst = 1'b0;

    // Store then load a word on A.
    access(1'b0, 1'b1, 3'b010, 32'd8, 32'hDEADBEEF, 1'b0, 32'h0, "a_sw8");
    access(1'b0, 1'b0, 3'b010, 32'd8, 32'h0, 1'b0, 32'hDEADBEEF, "a_lw8");

    // Misaligned halfword on B.
    access(1'b1, 1'b0, 3'b001, 32'd5, 32'h0, 1'b1, 32'h0, "b_lh5");

    // Byte store and signed/unsigned byte loads.
    access(1'b0, 1'b1, 3'b000, 32'd3, 32'h12345680, 1'b0, 32'h0, "a_sb3");
    access(1'b0, 1'b0, 3'b000, 32'd3, 32'h0, 1'b0, 32'hFFFFFF80, "a_lb3");
    access(1'b0, 1'b0, 3'b100, 32'd3, 32'h0, 1'b0, 32'h00000080, "a_lbu3");
    access(1'b0, 1'b0, 3'b010, 32'd0, 32'h0, 1'b0, 32'h00000080, "a_lw0");
    access(1'b1, 1'b0, 3'b001, 32'd8, 32'h0, 1'b0, 32'hFFFFDEAD, "b_lh8");
    access(1'b1, 1'b0, 3'b101, 32'd10, 32'h0, 1'b0, 32'h0000BEEF, "b_lhu10");

    // Boundary and illegal encodings.
    access(1'b0, 1'b0, 3'b010, 32'd62, 32'h0, 1'b1, 32'h0, "a_lw62");
    access(1'b0, 1'b0, 3'b010, 32'd60, 32'h0, 1'b0, 32'h0, "a_lw60");
    access(1'b0, 1'b0, 3'b001, 32'd62, 32'h0, 1'b0, 32'h0, "a_lh62");
    access(1'b0, 1'b1, 3'b000, 32'd64, 32'h55, 1'b1, 32'h0, "a_sb64");
    access(1'b0, 1'b0, 3'b111, 32'd0, 32'h0, 1'b1, 32'h0, "a_ctrl111");
    access(1'b0, 1'b1, 3'b100, 32'd0, 32'hFF, 1'b1, 32'h0, "a_sbu");
    access(1'b0, 1'b1, 3'b011, 32'd0, 32'hFF, 1'b1, 32'h0, "a_ctrl011");
    access(1'b0, 1'b0, 3'b010, 32'd0, 32'h0, 1'b0, 32'h00000080, "a_lw0_kept");

    // Reset during ACCESS of an A store; B queues behind it.
    access(1'b0, 1'b1, 3'b010, 32'd16, 32'hCAFEF00D, 1'b0, 32'h0, "a_sw16");
    @(negedge clk);
    ReqA = 1'b1; WrA = 1'b1; CtrlA = 3'b010; AddrA = 32'd16; DataWrA = 32'h11223344;
    wc0 = wr_cnt;
    @(negedge clk);
    check("r6_gnta", 32'(GntA), 32'd1);
    rst = 1'b1;
    ReqA = 1'b0;
    ReqB = 1'b1; WrB = 1'b0; CtrlB = 3'b010; AddrB = 32'd16;
    #1;
    check("r6_dmwr_forced", 32'(DMWr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("r6_no_rdya", {30'd0, RdyA, GntB}, 32'd0);
    @(negedge clk);
    check("r6_gntb", 32'(GntB), 32'd1);
    ReqB = 1'b0;
    @(negedge clk);
    check("r6_rdyb", {30'd0, RdyB, RdyA}, 32'h2);
    check("r6_mem_kept", DataRdB, 32'hCAFEF00D);
    check("r6_wrcnt", 32'(wr_cnt - wc0), 32'd0);

    // Contention: round-robin on dut, fixed priority on dut0.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    WrA = 1'b0; WrB = 1'b0; CtrlA = 3'b010; CtrlB = 3'b010;
    AddrA = 32'd0; AddrB = 32'd4;
    ReqA = 1'b1; ReqB = 1'b1;
    gs = 4'b0; gs0 = 4'b0; n = 0; n0 = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (GntA || GntB) begin
        if (n < 4) gs[n] = GntB;
        n++;
      end
      if (GntA0 || GntB0) begin
        if (n0 < 4) gs0[n0] = GntB0;
        n0++;
      end
    end
    check("fair1_count", 32'(n), 32'd4);
    check("fair1_order", {28'd0, gs}, 32'hA);
    check("fair0_count", 32'(n0), 32'd4);
    check("fair0_order", {28'd0, gs0}, 32'h0);
    ReqA = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (GntB0) begin
        found = 1'b1;
        ReqB = 1'b0;
      end
    end
    ReqB = 1'b0;
    check("fair0_b_after_a", 32'(found), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
